// File: rtl/pulse_gen_pkg.sv
// Shared types and default widths for the pulse generator.
package pulse_gen_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIGH = 2'd1,
        GAP  = 2'd2
    } state_t;

    localparam int unsigned LEN_W_DEF  = 8;
    localparam int unsigned GAP_W_DEF  = 8;
    localparam int unsigned PEND_W_DEF = 3;

    function automatic int unsigned max_w(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/pulse_pend_ctr.sv
// Saturating pending-trigger counter with sticky overflow flag.
module pulse_pend_ctr
    import pulse_gen_pkg::*;
#(
    parameter int unsigned PEND_W = PEND_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              inc,
    input  logic              dec,
    input  logic              ovf_clr,
    output logic [PEND_W-1:0] cnt,
    output logic              ovf
);

    logic [PEND_W-1:0] cnt_q, cnt_d;
    logic              ovf_q, ovf_d;
    logic              drop;

    // Simultaneous inc and dec cancel; an inc at saturation is dropped.
    always_comb begin
        cnt_d = cnt_q;
        ovf_d = ovf_q;
        drop  = 1'b0;
        if (inc && !dec) begin
            if (cnt_q == '1) begin
                drop = 1'b1;
            end else begin
                cnt_d = cnt_q + PEND_W'(1);
            end
        end else if (dec && !inc && (cnt_q != '0)) begin
            cnt_d = cnt_q - PEND_W'(1);
        end
        if (drop) begin
            ovf_d = 1'b1;
        end else if (ovf_clr) begin
            ovf_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
            ovf_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            ovf_q <= ovf_d;
        end
    end

    assign cnt = cnt_q;
    assign ovf = ovf_q;

endmodule

// File: rtl/pulse_gen.sv
// Stretches single-cycle triggers into programmable-width level pulses with a low gap.
module pulse_gen
    import pulse_gen_pkg::*;
#(
    parameter int unsigned LEN_W  = LEN_W_DEF,
    parameter int unsigned GAP_W  = GAP_W_DEF,
    parameter int unsigned PEND_W = PEND_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              pulse_sig,
    input  logic [LEN_W-1:0]  cfg_len,
    input  logic [GAP_W-1:0]  cfg_gap,
    input  logic              cfg_retrig,
    input  logic              ovf_clr,
    output logic              sig,
    output logic              busy,
    output logic [PEND_W-1:0] pend_cnt,
    output logic              ovf
);

    localparam int unsigned CNT_W = max_w(LEN_W, GAP_W);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             sig_q, sig_d;
    logic             pend_inc, pend_dec;
    logic             q_trig, r_trig, have_pend;
    logic [CNT_W-1:0] len_m1, gap_m1;

    assign q_trig    = pulse_sig & ~cfg_retrig;
    assign r_trig    = pulse_sig &  cfg_retrig;
    // A queue-mode trigger on the dequeue edge is serviced immediately.
    assign have_pend = (pend_cnt != '0) || q_trig;
    assign len_m1    = (cfg_len == '0) ? '0 : CNT_W'(cfg_len - LEN_W'(1));
    assign gap_m1    = CNT_W'(cfg_gap - GAP_W'(1));

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        sig_d    = sig_q;
        pend_inc = 1'b0;
        pend_dec = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (pulse_sig) begin
                    state_d = HIGH;
                    sig_d   = 1'b1;
                    cnt_d   = len_m1;
                end
            end
            HIGH: begin
                pend_inc = q_trig;
                if (r_trig) begin
                    cnt_d = len_m1;
                end else if (cnt_q == '0) begin
                    if (cfg_gap != '0) begin
                        state_d = GAP;
                        sig_d   = 1'b0;
                        cnt_d   = gap_m1;
                    end else if (have_pend) begin
                        cnt_d    = len_m1;
                        pend_dec = 1'b1;
                    end else begin
                        state_d = IDLE;
                        sig_d   = 1'b0;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            GAP: begin
                pend_inc = q_trig;
                if (r_trig) begin
                    state_d = HIGH;
                    sig_d   = 1'b1;
                    cnt_d   = len_m1;
                end else if (cnt_q == '0) begin
                    if (have_pend) begin
                        state_d  = HIGH;
                        sig_d    = 1'b1;
                        cnt_d    = len_m1;
                        pend_dec = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                sig_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            sig_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sig_q   <= sig_d;
        end
    end

    pulse_pend_ctr #(
        .PEND_W (PEND_W)
    ) u_pend (
        .clk     (clk),
        .rst     (rst),
        .inc     (pend_inc),
        .dec     (pend_dec),
        .ovf_clr (ovf_clr),
        .cnt     (pend_cnt),
        .ovf     (ovf)
    );

    assign sig  = sig_q;
    assign busy = (state_q != IDLE);

endmodule

// File: tb/tb_pulse_gen.sv
// Scenario bench for pulse_gen: expected sig/busy per cycle go through a scoreboard queue.
module tb_pulse_gen;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       pulse_sig = 1'b0;
    logic [7:0] cfg_len = 8'd0;
    logic [7:0] cfg_gap = 8'd0;
    logic       cfg_retrig = 1'b0;
    logic       ovf_clr = 1'b0;
    logic       sig;
    logic       busy;
    logic [2:0] pend_cnt;
    logic       ovf;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic sig;
        logic busy;
    } exp_t;

    exp_t exp_q[$];

    always #5 clk = ~clk;

    pulse_gen #(
        .LEN_W  (8),
        .GAP_W  (8),
        .PEND_W (3)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .pulse_sig  (pulse_sig),
        .cfg_len    (cfg_len),
        .cfg_gap    (cfg_gap),
        .cfg_retrig (cfg_retrig),
        .ovf_clr    (ovf_clr),
        .sig        (sig),
        .busy       (busy),
        .pend_cnt   (pend_cnt),
        .ovf        (ovf)
    );

    // Push the expected post-edge outputs, clock once, then score sig/busy.
    task automatic step(input logic trig, input logic e_sig, input logic e_busy, input string tag);
        exp_t e;
        exp_q.push_back('{sig: e_sig, busy: e_busy});
        pulse_sig = trig;
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL %s: scoreboard empty", tag);
        end else begin
            e = exp_q.pop_front();
            checks++;
            if (sig !== e.sig) begin
                errors++;
                $display("FAIL %s sig: got %b want %b at %0t", tag, sig, e.sig, $time);
            end
            checks++;
            if (busy !== e.busy) begin
                errors++;
                $display("FAIL %s busy: got %b want %b at %0t", tag, busy, e.busy, $time);
            end
        end
        pulse_sig = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step(1'b0, 1'b0, 1'b0, "reset");
        checks++;
        if (pend_cnt !== 3'd0) begin
            errors++;
            $display("FAIL reset pend_cnt: got %0d want 0", pend_cnt);
        end
        checks++;
        if (ovf !== 1'b0) begin
            errors++;
            $display("FAIL reset ovf: got %b want 0", ovf);
        end
        rst = 1'b0;
    endtask

    task automatic test_single();
        cfg_len = 8'd4; cfg_gap = 8'd2; cfg_retrig = 1'b0;
        step(1'b1, 1'b1, 1'b1, "single_hi");
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b1, "single_hi");
        for (int i = 0; i < 2; i++) step(1'b0, 1'b0, 1'b1, "single_gap");
        step(1'b0, 1'b0, 1'b0, "single_idle");
        checks++;
        if (pend_cnt !== 3'd0) begin
            errors++;
            $display("FAIL single pend_cnt: got %0d want 0", pend_cnt);
        end
    endtask

    task automatic test_len0();
        cfg_len = 8'd0; cfg_gap = 8'd0; cfg_retrig = 1'b0;
        step(1'b1, 1'b1, 1'b1, "len0_one");
        step(1'b0, 1'b0, 1'b0, "len0_one_end");
        step(1'b1, 1'b1, 1'b1, "len0_b2b_a");
        step(1'b1, 1'b1, 1'b1, "len0_b2b_b");
        step(1'b0, 1'b0, 1'b0, "len0_b2b_end");
        checks++;
        if (pend_cnt !== 3'd0) begin
            errors++;
            $display("FAIL len0 pend_cnt: got %0d want 0", pend_cnt);
        end
    endtask

    // Four triggers back to back: four pulses of 3 high / 2 low.
    task automatic test_queue();
        cfg_len = 8'd3; cfg_gap = 8'd2; cfg_retrig = 1'b0;
        for (int p = 0; p < 4; p++) begin
            for (int h = 0; h < 3; h++) begin
                step(p == 0, 1'b1, 1'b1, "queue_hi");
                if (h == 0 && p > 0) begin
                    checks++;
                    if (pend_cnt !== 3'(3 - p)) begin
                        errors++;
                        $display("FAIL queue pend pulse%0d: got %0d want %0d", p, pend_cnt, 3 - p);
                    end
                end
            end
            for (int g = 0; g < 2; g++) begin
                step(p == 0 && g == 0, 1'b0, 1'b1, "queue_gap");
                if (p == 0 && g == 0) begin
                    checks++;
                    if (pend_cnt !== 3'd3) begin
                        errors++;
                        $display("FAIL queue pend peak: got %0d want 3", pend_cnt);
                    end
                end
            end
        end
        step(1'b0, 1'b0, 1'b0, "queue_idle");
    endtask

    task automatic test_overflow();
        cfg_len = 8'd20; cfg_gap = 8'd0; cfg_retrig = 1'b0;
        step(1'b1, 1'b1, 1'b1, "ovf_start");
        for (int i = 0; i < 9; i++) step(1'b1, 1'b1, 1'b1, "ovf_fill");
        checks++;
        if (pend_cnt !== 3'd7) begin
            errors++;
            $display("FAIL ovf pend_cnt: got %0d want 7", pend_cnt);
        end
        checks++;
        if (ovf !== 1'b1) begin
            errors++;
            $display("FAIL ovf set: got %b want 1", ovf);
        end
        ovf_clr = 1'b1;
        step(1'b0, 1'b1, 1'b1, "ovf_clr");
        checks++;
        if (ovf !== 1'b0) begin
            errors++;
            $display("FAIL ovf clear: got %b want 0", ovf);
        end
        step(1'b1, 1'b1, 1'b1, "ovf_clr_drop");
        ovf_clr = 1'b0;
        checks++;
        if (ovf !== 1'b1) begin
            errors++;
            $display("FAIL ovf set_wins: got %b want 1", ovf);
        end
        checks++;
        if (pend_cnt !== 3'd7) begin
            errors++;
            $display("FAIL ovf pend_hold: got %0d want 7", pend_cnt);
        end
        // Gapless reload: sig stays high across the pulse boundary and one entry drains.
        for (int i = 0; i < 9; i++) step(1'b0, 1'b1, 1'b1, "ovf_drain");
        checks++;
        if (pend_cnt !== 3'd6) begin
            errors++;
            $display("FAIL ovf pend_drain: got %0d want 6", pend_cnt);
        end
        rst = 1'b1;
        step(1'b0, 1'b0, 1'b0, "ovf_rst");
        rst = 1'b0;
        checks++;
        if (ovf !== 1'b0 || pend_cnt !== 3'd0) begin
            errors++;
            $display("FAIL ovf after_rst: got ovf=%b pend=%0d want ovf=0 pend=0", ovf, pend_cnt);
        end
    endtask

    task automatic test_retrig();
        cfg_len = 8'd5; cfg_gap = 8'd3; cfg_retrig = 1'b1;
        step(1'b1, 1'b1, 1'b1, "retrig_hi");
        step(1'b0, 1'b1, 1'b1, "retrig_hi");
        step(1'b0, 1'b1, 1'b1, "retrig_hi");
        step(1'b1, 1'b1, 1'b1, "retrig_ext");
        checks++;
        if (pend_cnt !== 3'd0) begin
            errors++;
            $display("FAIL retrig no_queue: got %0d want 0", pend_cnt);
        end
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 1'b1, "retrig_ext_hi");
        step(1'b0, 1'b0, 1'b1, "retrig_gap1");
        step(1'b0, 1'b0, 1'b1, "retrig_gap2");
        step(1'b1, 1'b1, 1'b1, "retrig_abort");
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 1'b1, "retrig_abort_hi");
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b1, "retrig_gap");
        step(1'b0, 1'b0, 1'b0, "retrig_idle");
        cfg_retrig = 1'b0;
    endtask

    task automatic test_reset_mid();
        cfg_len = 8'd6; cfg_gap = 8'd0; cfg_retrig = 1'b0;
        step(1'b1, 1'b1, 1'b1, "rmid_hi");
        step(1'b1, 1'b1, 1'b1, "rmid_hi");
        step(1'b1, 1'b1, 1'b1, "rmid_hi");
        checks++;
        if (pend_cnt !== 3'd2) begin
            errors++;
            $display("FAIL rmid pend_before: got %0d want 2", pend_cnt);
        end
        rst = 1'b1;
        step(1'b0, 1'b0, 1'b0, "rmid_rst");
        rst = 1'b0;
        checks++;
        if (pend_cnt !== 3'd0) begin
            errors++;
            $display("FAIL rmid pend_after: got %0d want 0", pend_cnt);
        end
        cfg_len = 8'd2; cfg_gap = 8'd1;
        step(1'b1, 1'b1, 1'b1, "rmid_new_hi");
        step(1'b0, 1'b1, 1'b1, "rmid_new_hi");
        step(1'b0, 1'b0, 1'b1, "rmid_new_gap");
        step(1'b0, 1'b0, 1'b0, "rmid_new_idle");
    endtask

    initial begin
        test_reset();
        test_single();
        test_len0();
        test_queue();
        test_overflow();
        test_retrig();
        test_reset_mid();
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard leftover: %0d entries want 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pulse_gen.md
Name: pulse_gen

Overview:
- Inverse of the edge/pulse detector: it turns single-cycle trigger pulses (`pulse_sig`) back into level pulses of programmable width.
- Each pulse is followed by a programmable low gap. Triggers that arrive while busy are either queued or extend the current pulse (retrigger mode).
- Sits downstream of `pulse_det` outputs or any event strobe that must drive a stretched, rate-limited level (LED/strobe/enable lines).

Parameters:
- `LEN_W`, 8, width of `cfg_len` (pulse high length in cycles).
- `GAP_W`, 8, width of `cfg_gap` (minimum low gap in cycles).
- `PEND_W`, 3, width of the pending-trigger counter; max pending = 2^PEND_W-1.

Ports:
- `clk`  in  1  system clock, all logic on rising edge.
- `rst`  in  1  synchronous reset, active-high.
- `pulse_sig`  in  1  trigger; sampled every cycle, each high cycle is one trigger.
- `cfg_len`  in  LEN_W  high length; 0 is treated as 1.
- `cfg_gap`  in  GAP_W  low gap after each pulse; 0 means no gap.
- `cfg_retrig`  in  1  1 = retrigger/extend mode, 0 = queue mode.
- `ovf_clr`  in  1  clears sticky overflow.
- `sig`  out  1  registered stretched output level.
- `busy`  out  1  state != IDLE.
- `pend_cnt`  out  PEND_W  queued triggers not yet serviced.
- `ovf`  out  1  sticky: a trigger was dropped because the queue was full.

Behaviour:
- Reset (`rst`=1 at an edge): state=IDLE; `sig`=0, `busy`=0, `pend_cnt`=0, `ovf`=0. Reset mid-pulse drops `sig` at that edge and discards pending triggers.
- FSM states are IDLE, HIGH, GAP. A down-counter `cnt` is wide enough for max(LEN_W, GAP_W).
- IDLE: trigger sampled at edge E0 -> HIGH at E0, `sig`=1 from E0, `cnt`=max(cfg_len,1)-1. Latency is one edge from the trigger to `sig` high.
- HIGH: decrement `cnt` each edge. At the edge where `cnt`==0:
  - `cfg_gap`>0 -> GAP, `sig`=0, `cnt`=cfg_gap-1.
  - `cfg_gap`==0 and `pend_cnt`>0 -> stay HIGH, reload the length, decrement `pend_cnt`; `sig` stays high continuously.
  - Otherwise -> IDLE, `sig`=0.
- `sig` is therefore high for exactly L=max(cfg_len,1) cycles per serviced trigger.
- GAP: decrement each edge. At `cnt`==0: `pend_cnt`>0 -> HIGH (reload length, `pend_cnt`-1, `sig`=1), else -> IDLE.
- `cfg_len` and `cfg_gap` are sampled at each load (pulse start / gap start). Mid-pulse changes do not affect the running count.
- Queue mode (`cfg_retrig`=0), trigger while HIGH/GAP:
  - `pend_cnt`+1, saturating at the maximum.
  - A trigger arriving at the maximum is dropped and sets `ovf`.
  - A trigger in the same cycle as a dequeue leaves `pend_cnt` unchanged; this never overflows.
  - A trigger on the IDLE->HIGH edge is the starting trigger itself.
- Retrigger mode (`cfg_retrig`=1):
  - Trigger in HIGH reloads `cnt`=L-1, extending the pulse; `sig` stays high.
  - Trigger in GAP aborts the gap -> HIGH at that edge.
  - No new triggers are queued; an existing `pend_cnt` still drains normally.
- `ovf`: set on a drop, cleared by `ovf_clr`. A drop and `ovf_clr` in the same cycle leaves `ovf`=1 (set wins).
- `busy` is combinational from the state register; all other outputs are registered.

Decomposition:
- Package `pulse_gen_pkg`: `state_t` enum {IDLE, HIGH, GAP}; default width localparams.
- Sub-module `pulse_pend_ctr`: saturating up/down counter with inc, dec, sticky ovf and ovf_clr. Simultaneous inc+dec means hold.
- The FSM and length/gap counter stay in `pulse_gen`.

Test Plan:
- Single trigger, queue mode, len=4 gap=2 -> `sig` high cycles 1-4 after the trigger sample, `busy` high 6 cycles, then IDLE with `pend_cnt`=0.
- len=0, gap=0 -> 1-cycle `sig` pulse. Two triggers 1 cycle apart in queue mode -> `sig` high 2 consecutive cycles, no low between.
- Queue: len=3 gap=2, 3 extra triggers during the first pulse -> 4 pulses of 3 high/2 low; `pend_cnt` reads 3,2,1,0 at successive pulse starts.
- Overflow: PEND_W=3, 9 triggers during a len=20 pulse -> `pend_cnt`=7, `ovf`=1. `ovf_clr` alone -> `ovf`=0. `ovf_clr` plus a dropped trigger in the same cycle -> `ovf`=1.
- Retrigger: len=5 gap=3, second trigger on the 3rd high cycle -> `sig` high 8 continuous cycles. Trigger on the 2nd gap cycle -> `sig` high at the next edge for 5 cycles.
- Reset mid-HIGH with `pend_cnt`=2 -> `sig`=0, `busy`=0, `pend_cnt`=0 after the reset edge. The first trigger after reset produces a normal pulse.
